// File: rtl/aes_shift_rows_stream_if.sv
// Byte-stream handshake bundle for the ShiftRows engine: input byte channel and
// output byte channel with last-byte marker. slave = engine side, master = producer/consumer side.
interface aes_shift_rows_stream_if;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_data_o;
    logic       out_last_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_last_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o
    );
endinterface

// File: rtl/aes_shift_rows_stream.sv
// Byte-serial ShiftRows/InvShiftRows for NB = 4/6/8 column Rijndael states.
// Latency: first output byte the cycle after the last input byte; 2N cycles per block unstalled.
// Backpressure: single buffer, input stalls for the whole drain; output held stable while !out_ready_i.
package aes_shift_rows_pkg;
    typedef enum logic {
        ENCRYPT = 1'b0,
        DECRYPT = 1'b1
    } mode_t;
endpackage

module aes_shift_rows_stream
    import aes_shift_rows_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  mode_t                   mode_i,
    input  logic                    flush_i,
    aes_shift_rows_stream_if.slave  bus
);
    localparam int N    = 4 * NB;
    localparam int CW   = $clog2(N);
    localparam int COLW = CW - 2;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("aes_shift_rows_stream: NB must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    mode_t         mode_q;
    logic          in_rdy_q;
    logic          out_vld_q;
    logic [7:0]    mem_q [N];

    logic          in_hs;
    logic          cnt_last;

    assign in_hs    = bus.in_valid_i & in_rdy_q;
    assign cnt_last = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            mode_q    <= ENCRYPT;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else if (flush_i) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_hs) begin
                        if (cnt_q == '0) begin
                            mode_q <= mode_i;
                        end
                        if (cnt_last) begin
                            state_q   <= DRAIN;
                            cnt_q     <= '0;
                            in_rdy_q  <= 1'b0;
                            out_vld_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready_i) begin
                        if (cnt_last) begin
                            state_q   <= LOAD;
                            cnt_q     <= '0;
                            in_rdy_q  <= 1'b1;
                            out_vld_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= LOAD;
                    cnt_q     <= '0;
                    in_rdy_q  <= 1'b1;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // State buffer carries no reset; its contents are only observed in DRAIN.
    always_ff @(posedge clk) begin
        if (in_hs && !flush_i) begin
            mem_q[cnt_q] <= bus.in_data_i;
        end
    end

    logic [1:0]    row;
    logic [3:0]    col;
    logic [3:0]    shift;
    logic [3:0]    scol_raw;
    logic [3:0]    scol;
    logic [CW-1:0] src;

    // Source column wraps with a single conditional subtract so NB = 6 wraps correctly.
    always_comb begin
        row   = cnt_q[1:0];
        col   = 4'(cnt_q[CW-1:2]);
        shift = 4'd0;
        case (row)
            2'd0: shift = 4'd0;
            2'd1: shift = 4'd1;
            2'd2: shift = (NB == 8) ? 4'd3 : 4'd2;
            2'd3: shift = (NB == 8) ? 4'd4 : 4'd3;
            default: shift = 4'd0;
        endcase
        if (mode_q == ENCRYPT) begin
            scol_raw = col + shift;
        end else begin
            scol_raw = col + 4'(NB) - shift;
        end
        scol = (scol_raw >= 4'(NB)) ? (scol_raw - 4'(NB)) : scol_raw;
        src  = {scol[COLW-1:0], row};
    end

    assign bus.in_ready_o  = in_rdy_q;
    assign bus.out_valid_o = out_vld_q;
    assign bus.out_last_o  = out_vld_q & cnt_last;
    assign bus.out_data_o  = out_vld_q ? mem_q[src] : 8'h00;

endmodule
